rot_arbiter: RTL and testbench
==============================

Name: rot_arbiter

Overview:
Shares one 32-bit circular-left-rotate datapath among NUM_REQ requesters.
- Each requester presents an operand and a rotate amount over a valid/ready handshake.
- A round-robin arbiter grants one request per cycle; the rotated result is registered and returned on a single response channel tagged with the requester index.
- Sits between the instruction/crypto front-ends and the shared rotator, so the front-ends never instantiate their own.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of response tag (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data  in  NUM_REQ*32  packed operands, requester i at [32*i+31:32*i]
req_amt  in  NUM_REQ*5  packed rotate amounts, requester i at [5*i+4:5*i]
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accepts result
rsp_data  out  32  rotated result
rsp_id  out  ID_W  index of requester that issued the result

Behaviour:
- Rotate function: rsp_data = (a << n) | (a >> (32-n)), with n = amt[4:0]. n=0 passes a unchanged. All 32 amounts are legal and must be exact.
- Reset (async assert, sync deassert by system): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0. req_ready=0 while rst_n low.
- Issue condition: can_issue = !rsp_valid || rsp_ready (single output register; no skid buffer).
- Arbitration: among requesters with req_valid=1, grant the first found scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
- req_ready[g]=1 only for the granted g, and only when can_issue. All other bits are 0. req_ready is combinational from req_valid, rr_ptr and the output state.
- On handshake (req_valid[g] && req_ready[g]):
  - next cycle rsp_valid=1, rsp_data=rotl(req_data[g], req_amt[g]), rsp_id=g;
  - rr_ptr <= (g+1) mod NUM_REQ.
- No handshake: rr_ptr holds.
- Latency: exactly 1 cycle, request handshake to rsp_valid.
- Throughput: 1 result/cycle while rsp_ready=1.
- Response hold: while rsp_valid && !rsp_ready, rsp_data and rsp_id are stable and no request is accepted (all req_ready=0).
- Simultaneous consume and issue (rsp_valid && rsp_ready && new grant): the register reloads with the new result; rsp_valid stays 1 with no bubble.
- Consume with no pending request: rsp_valid falls to 0; rsp_data/rsp_id hold their last values (don't-care).
- Requester protocol: once req_valid[i] rises, it and its data/amt hold until accepted. The bench flags violations; the RTL does not check.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,NUM_REQ-1,0. Worst-case wait is NUM_REQ-1 grants.
- Reset mid-operation: any in-flight result is dropped, rsp_valid clears immediately, rr_ptr returns to 0. Requesters must re-present.

Decomposition:
- Package rot_pkg: DATA_W=32, AMT_W=5, typedefs data_t (logic[31:0]) and amt_t (logic[4:0]), and function rotl(data_t, amt_t) for the bench reference model.
- Sub-module rot32_core: purely combinational rotator (a, amt -> o), implemented as a 5-stage log shifter. rot_arbiter instantiates it once on the granted operand mux output.
- Arbiter logic (priority scan from rr_ptr) stays inline.

Test Plan:
1. Reset check: rst_n low with all req_valid=1 -> rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0000. After release, first grant goes to requester 0.
2. Single request, requester 2, data 0x12345678, amt 6 -> req_ready=0100 that cycle; next cycle rsp_valid=1, rsp_data=0x8D159E04, rsp_id=2.
3. Amount corners, requester 1, rsp_ready=1:
   - 0xDEADBEEF, amt 0 -> 0xDEADBEEF;
   - 0x80000001, amt 1 -> 0x00000003;
   - 0x00000001, amt 31 -> 0x80000000;
   - full sweep amt 0..31 on 0x12345678 matches rotl.
4. All four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
5. Backpressure: hold rsp_ready=0 for 3 cycles with all requesters valid -> rsp_data/rsp_id stable, req_ready=0000. On rsp_ready=1, the next grant follows round-robin order.
6. Reset mid-stream: assert rst_n low while rsp_valid=1 -> rsp_valid drops asynchronously. After release, grant restarts at requester 0 and the dropped result is never re-emitted.

Source files
------------

// File: rtl/rot_pkg.sv
// rot_pkg: shared widths, types and reference rotate for the rotator slice
package rot_pkg;
    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [AMT_W-1:0]  amt_t;
    function automatic data_t rotl(input data_t a, input amt_t n);
        return (a << n) | (a >> (DATA_W - int'(n)));
    endfunction
endpackage

// File: rtl/rot32_core.sv
// rot32_core: combinational 32-bit rotate-left as a 5-stage log shifter
module rot32_core
    import rot_pkg::*;
(
    input  data_t a,
    input  amt_t  amt,
    output data_t o
);
    data_t s [AMT_W+1];
    assign s[0] = a;
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign s[k+1] = amt[k] ? {s[k][DATA_W-1-SH:0], s[k][DATA_W-1:DATA_W-SH]} : s[k];
    end
    assign o = s[AMT_W];
endmodule

// File: rtl/rot_arbiter.sv
// rot_arbiter: round-robin arbiter sharing one registered 32-bit rotator
module rot_arbiter
    import rot_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*AMT_W-1:0]  req_amt,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id
);
    logic [ID_W-1:0] rr_ptr, gnt, idx;
    logic            hit, fire;
    data_t           d_arr [NUM_REQ];
    amt_t            a_arr [NUM_REQ];
    data_t           rot;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign d_arr[g] = req_data[g*DATA_W +: DATA_W];
        assign a_arr[g] = req_amt[g*AMT_W +: AMT_W];
    end
    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        gnt = '0;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!hit && req_valid[idx]) begin
                hit = 1'b1;
                gnt = idx;
            end
        end
    end
    assign fire      = hit && (!rsp_valid || rsp_ready);
    assign req_ready = (fire && rst_n) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt : '0;
    rot32_core u_rot (.a(d_arr[gnt]), .amt(a_arr[gnt]), .o(rot));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rot;
            rsp_id    <= gnt;
            rr_ptr    <= (gnt == ID_W'(NUM_REQ-1)) ? '0 : gnt + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rot_arbiter.sv
// tb_rot_arbiter: directed checks of grant order, rotate results, backpressure and reset
module tb_rot_arbiter;
    import rot_pkg::*;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_data;
    logic [19:0]  req_amt;
    logic         rsp_valid, rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    int checks = 0;
    int errors = 0;
    data_t exp_d [4];

    rot_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] a);
        req_data[32*i +: 32] = d;
        req_amt[5*i +: 5]    = a;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_data = '0;
        req_amt = '0;
        set_req(0, 32'h000000FF, 5'd4);
        set_req(1, 32'hF0000000, 5'd8);
        set_req(2, 32'h12345678, 5'd6);
        set_req(3, 32'hA5A5A5A5, 5'd1);
        exp_d[0] = 32'h00000FF0;
        exp_d[1] = 32'h000000F0;
        exp_d[2] = 32'h8D159E04;
        exp_d[3] = 32'h4B4B4B4B;
        // Reset with everyone requesting
        step();
        step();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 32'(req_ready), 32'b0001);
        // All valid, rsp_ready=1: 0,1,2,3,0,1 back to back
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rr_valid%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("rr_id%0d", i), 32'(rsp_id), 32'(i % 4));
            chk($sformatf("rr_data%0d", i), rsp_data, exp_d[i % 4]);
            if (i < 5) chk($sformatf("rr_ready%0d", i), 32'(req_ready), 32'(1 << ((i + 1) % 4)));
        end
        // Backpressure: result 1 must hold, nothing accepted
        rsp_ready = 1'b0;
        #1;
        chk("bp_ready0", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_id%0d", i), 32'(rsp_id), 32'd1);
            chk($sformatf("bp_data%0d", i), rsp_data, exp_d[1]);
            chk($sformatf("bp_ready%0d", i + 1), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(req_ready), 32'b0100);
        step();
        chk("bp_resume_id", 32'(rsp_id), 32'd2);
        chk("bp_resume_data", rsp_data, exp_d[2]);
        // Reset mid-stream drops the in-flight result immediately
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        step();
        req_valid = 4'b1010;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b0010);
        step();
        chk("post_rst_id1", 32'(rsp_id), 32'd1);
        chk("post_rst_data1", rsp_data, exp_d[1]);
        chk("post_rst_ready3", 32'(req_ready), 32'b1000);
        step();
        chk("post_rst_id3", 32'(rsp_id), 32'd3);
        chk("post_rst_data3", rsp_data, exp_d[3]);
        // Single request from requester 2
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_data", rsp_data, 32'h8D159E04);
        // Amount corners then full sweep on requester 1
        req_valid = 4'b0010;
        for (int i = 0; i < 35; i++) begin
            data_t d, e;
            amt_t  a;
            if (i == 0) begin d = 32'hDEADBEEF; a = 5'd0;  e = 32'hDEADBEEF; end
            else if (i == 1) begin d = 32'h80000001; a = 5'd1;  e = 32'h00000003; end
            else if (i == 2) begin d = 32'h00000001; a = 5'd31; e = 32'h80000000; end
            else begin d = 32'h12345678; a = 5'(i - 3); e = rotl(d, a); end
            set_req(1, d, a);
            #1;
            chk($sformatf("amt_ready%0d", i), 32'(req_ready), 32'b0010);
            step();
            chk($sformatf("amt_id%0d", i), 32'(rsp_id), 32'd1);
            chk($sformatf("amt_data%0d", i), rsp_data, e);
        end
        req_valid = 4'b0000;
        step();
        chk("drain_valid", 32'(rsp_valid), 32'd0);
        chk("drain_hold_id", 32'(rsp_id), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
